// File: rtl/clken_pkg.sv
// Shared constants and helpers for the clock-enable counter generator.
// Build option: define CLKEN_CNT_SAT_EN to make the event counter saturate
// at its limits instead of wrapping modulo 2**CNT_W.
package clken_pkg;

    // Default configuration: 8-bit divide ratio, 4-bit event counter and a
    // divide-by-20 tick after reset, matching the fixed design this replaces.
    localparam int CLKEN_DIV_W   = 8;
    localparam int CLKEN_CNT_W   = 4;
    localparam int CLKEN_DIV_RST = 20;

    // Count direction encoding of the cnt_dir input.
    localparam logic CNT_UP = 1'b0;
    localparam logic CNT_DN = 1'b1;

    // Value a width-bit counter cannot move past in the given direction:
    // all-ones when counting up, zero when counting down. Width must lie
    // in 1..32; callers cast the result to their own counter width.
    function automatic logic [31:0] cnt_limit(input int unsigned width,
                                              input logic        dir);
        logic [31:0] all_ones;
        all_ones = 32'hFFFF_FFFF >> (32 - width);
        if (dir == CNT_DN) begin
            return 32'd0;
        end
        return all_ones;
    endfunction

endpackage : clken_pkg

// File: rtl/clken_prescaler.sv
// Runtime-programmable prescaler: emits a registered one-cycle enable pulse
// every div_r system clocks while run is high. A div_load strobe latches a
// new ratio (0 is treated as 1) and restarts the period from zero.
module clken_prescaler
    import clken_pkg::*;
#(
    parameter int DIV_W   = CLKEN_DIV_W,
    parameter int DIV_RST = CLKEN_DIV_RST
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_i,
    input  logic [DIV_W-1:0] div_val_i,
    input  logic             div_load_i,
    output logic             clk_en_o
);

    localparam logic [DIV_W-1:0] DIV_RST_V = DIV_W'(DIV_RST);
    localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic [DIV_W-1:0] divcnt_q;
    logic [DIV_W-1:0] divcnt_d;
    logic             clk_en_q;
    logic             clk_en_d;
    logic             term;

    // Last count of the current period; div_q is never zero so this cannot
    // underflow.
    assign term = (divcnt_q == (div_q - ONE));

    // Next-state: a load beats counting and discards any terminal count that
    // happens to coincide with it; with run low everything holds and the
    // enable drops.
    always_comb begin
        div_d    = div_q;
        divcnt_d = divcnt_q;
        clk_en_d = 1'b0;
        if (div_load_i) begin
            div_d    = (div_val_i == '0) ? ONE : div_val_i;
            divcnt_d = '0;
            clk_en_d = 1'b0;
        end else if (run_i) begin
            divcnt_d = term ? '0 : (divcnt_q + ONE);
            clk_en_d = term;
        end
    end

    // State registers, cleared asynchronously to the reset ratio.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q    <= DIV_RST_V;
            divcnt_q <= '0;
            clk_en_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            divcnt_q <= divcnt_d;
            clk_en_q <= clk_en_d;
        end
    end

    assign clk_en_o = clk_en_q;

endmodule : clken_prescaler

// File: rtl/clken_counter_gen.sv
// Common slow-tick source: a programmable prescaler feeding an up/down event
// counter with synchronous clear and a registered wrap pulse. No derived
// clocks are produced; everything runs on clk.
// Build option: CLKEN_CNT_SAT_EN selects a saturating counter (wrap then
// flags a counting edge that arrives at the limit); otherwise the counter
// wraps modulo 2**CNT_W. The port list is the same in both builds.
module clken_counter_gen
    import clken_pkg::*;
#(
    parameter int DIV_W   = CLKEN_DIV_W,
    parameter int CNT_W   = CLKEN_CNT_W,
    parameter int DIV_RST = CLKEN_DIV_RST
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [DIV_W-1:0] div_val,
    input  logic             div_load,
    input  logic             cnt_dir,
    input  logic             cnt_clr,
    output logic             clk_en,
    output logic [CNT_W-1:0] syscnt,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic             tick;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             wrap_q;
    logic             wrap_d;
    logic [CNT_W-1:0] limit;
    logic             at_limit;

    clken_prescaler #(
        .DIV_W   (DIV_W),
        .DIV_RST (DIV_RST)
    ) u_prescaler (
        .clk        (clk),
        .rst_n      (rst_n),
        .run_i      (run),
        .div_val_i  (div_val),
        .div_load_i (div_load),
        .clk_en_o   (tick)
    );

    // Boundary the counter is about to cross in the current direction.
    assign limit    = CNT_W'(cnt_limit(CNT_W, cnt_dir));
    assign at_limit = (cnt_q == limit);

    // Next-state: clear beats counting; a tick only counts while run is
    // still high, so a pulse pending when run falls is dropped.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (cnt_clr) begin
            cnt_d  = '0;
            wrap_d = 1'b0;
        end else if (tick && run) begin
            if (at_limit) begin
                wrap_d = 1'b1;
`ifdef CLKEN_CNT_SAT_EN
                cnt_d  = cnt_q;
`else
                cnt_d  = (cnt_dir == CNT_DN) ? {CNT_W{1'b1}} : '0;
`endif
            end else if (cnt_dir == CNT_DN) begin
                cnt_d = cnt_q - ONE;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end
    end

    // Counter and wrap-flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign clk_en = tick;
    assign syscnt = cnt_q;
    assign wrap   = wrap_q;

endmodule : clken_counter_gen

// File: tb/tb_clken_counter_gen.sv
// Directed bench for clken_counter_gen with default parameters
// (DIV_W=8, CNT_W=4, DIV_RST=20). Expectations follow CLKEN_CNT_SAT_EN.
module tb_clken_counter_gen;

    localparam int DIV_W = 8;
    localparam int CNT_W = 4;
`ifdef CLKEN_CNT_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    // Clock and reset
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             run = 1'b0;
    logic [DIV_W-1:0] div_val = '0;
    logic             div_load = 1'b0;
    logic             cnt_dir = 1'b0;
    logic             cnt_clr = 1'b0;
    logic             clk_en;
    logic [CNT_W-1:0] syscnt;
    logic             wrap;

    always #5 clk = ~clk;

    clken_counter_gen dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .div_val  (div_val),
        .div_load (div_load),
        .cnt_dir  (cnt_dir),
        .cnt_clr  (cnt_clr),
        .clk_en   (clk_en),
        .syscnt   (syscnt),
        .wrap     (wrap)
    );

    int vectors     = 0;
    int miscompares = 0;
    int now         = 0;   // rising edges since the last reset release

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to the falling edge just after rising edge number e.
    task automatic to_edge(input int e);
        while (now < e) begin
            @(negedge clk);
            now++;
        end
    endtask

    initial begin
        // Reset state
        run = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_clk_en", {7'd0, clk_en}, 8'd0);
        chk("rst_syscnt", {4'd0, syscnt}, 8'd0);
        chk("rst_wrap",   {7'd0, wrap},   8'd0);
        rst_n = 1'b1;
        now = 0;

        // Default divide-by-20
        to_edge(19);  chk("def_pre20",   {7'd0, clk_en}, 8'd0);
        to_edge(20);  chk("def_en20",    {7'd0, clk_en}, 8'd1);
                      chk("def_cnt20",   {4'd0, syscnt}, 8'd0);
        to_edge(21);  chk("def_off21",   {7'd0, clk_en}, 8'd0);
                      chk("def_cnt21",   {4'd0, syscnt}, 8'd1);
        to_edge(40);  chk("def_en40",    {7'd0, clk_en}, 8'd1);
        to_edge(41);  chk("def_cnt41",   {4'd0, syscnt}, 8'd2);
        to_edge(60);  chk("def_en60",    {7'd0, clk_en}, 8'd1);
        to_edge(61);  chk("def_cnt61",   {4'd0, syscnt}, 8'd3);
                      chk("def_wrap61",  {7'd0, wrap},   8'd0);

        // Load N=5 on the terminal-count edge 80: that pulse is discarded
        to_edge(79);
        div_val = 8'd5; div_load = 1'b1;
        to_edge(80);  div_load = 1'b0;
                      chk("ld_noen80",   {7'd0, clk_en}, 8'd0);
                      chk("ld_cnt80",    {4'd0, syscnt}, 8'd3);
        to_edge(84);  chk("ld_pre84",    {7'd0, clk_en}, 8'd0);
        to_edge(85);  chk("ld_en85",     {7'd0, clk_en}, 8'd1);
        to_edge(86);  chk("ld_cnt86",    {4'd0, syscnt}, 8'd4);
        to_edge(90);  chk("ld_en90",     {7'd0, clk_en}, 8'd1);
        to_edge(145); chk("up_cnt145",   {4'd0, syscnt}, 8'd15);
                      chk("up_wrap145",  {7'd0, wrap},   8'd0);
        to_edge(146); chk("up_cnt146",   {4'd0, syscnt}, SAT ? 8'd15 : 8'd0);
                      chk("up_wrap146",  {7'd0, wrap},   8'd1);
        to_edge(147); chk("up_wrap147",  {7'd0, wrap},   8'd0);

        // N=0 stored as 1: enable every cycle
        div_val = 8'd0; div_load = 1'b1; cnt_clr = 1'b1;
        to_edge(148); div_load = 1'b0; cnt_clr = 1'b0;
                      chk("n1_noen148",  {7'd0, clk_en}, 8'd0);
                      chk("n1_cnt148",   {4'd0, syscnt}, 8'd0);
        to_edge(149); chk("n1_en149",    {7'd0, clk_en}, 8'd1);
        to_edge(150); chk("n1_cnt150",   {4'd0, syscnt}, 8'd1);
        to_edge(153); chk("n1_en153",    {7'd0, clk_en}, 8'd1);
                      chk("n1_cnt153",   {4'd0, syscnt}, 8'd4);

        // Clear on a counting edge wins
        cnt_clr = 1'b1;
        to_edge(154); cnt_clr = 1'b0;
                      chk("clr_cnt154",  {4'd0, syscnt}, 8'd0);
                      chk("clr_wrap154", {7'd0, wrap},   8'd0);

        // Count down from zero
        cnt_dir = 1'b1;
        to_edge(155); chk("dn_cnt155",   {4'd0, syscnt}, SAT ? 8'd0 : 8'd15);
                      chk("dn_wrap155",  {7'd0, wrap},   8'd1);
        to_edge(156); chk("dn_cnt156",   {4'd0, syscnt}, SAT ? 8'd0 : 8'd14);
                      chk("dn_wrap156",  {7'd0, wrap},   SAT ? 8'd1 : 8'd0);
        cnt_dir = 1'b0;
        to_edge(157); chk("dir_cnt157",  {4'd0, syscnt}, SAT ? 8'd1 : 8'd15);
                      chk("dir_wrap157", {7'd0, wrap},   8'd0);

        // Run low for 7 cycles stretches the period by 7
        div_val = 8'd5; div_load = 1'b1; cnt_clr = 1'b1;
        to_edge(158); div_load = 1'b0; cnt_clr = 1'b0;
                      chk("hd_cnt158",   {4'd0, syscnt}, 8'd0);
                      chk("hd_en158",    {7'd0, clk_en}, 8'd0);
        to_edge(163); chk("hd_en163",    {7'd0, clk_en}, 8'd1);
        to_edge(164); chk("hd_cnt164",   {4'd0, syscnt}, 8'd1);
        to_edge(165); run = 1'b0;
        to_edge(170); chk("hd_hold170",  {7'd0, clk_en}, 8'd0);
                      chk("hd_cnt170",   {4'd0, syscnt}, 8'd1);
        to_edge(172); run = 1'b1;
        to_edge(174); chk("hd_pre174",   {7'd0, clk_en}, 8'd0);
        to_edge(175); chk("hd_en175",    {7'd0, clk_en}, 8'd1);
        to_edge(176); chk("hd_cnt176",   {4'd0, syscnt}, 8'd2);

        // Run falls while the enable is high: that pulse is not counted
        to_edge(180); chk("rf_en180",    {7'd0, clk_en}, 8'd1);
        run = 1'b0;
        to_edge(181); chk("rf_en181",    {7'd0, clk_en}, 8'd0);
                      chk("rf_cnt181",   {4'd0, syscnt}, 8'd2);
        run = 1'b1;
        to_edge(185); chk("rf_pre185",   {7'd0, clk_en}, 8'd0);
        to_edge(186); chk("rf_en186",    {7'd0, clk_en}, 8'd1);
                      chk("rf_cnt186",   {4'd0, syscnt}, 8'd2);

        // Asynchronous reset between edges, then the default ratio again
        #2 rst_n = 1'b0;
        #1;
        chk("ar_clk_en", {7'd0, clk_en}, 8'd0);
        chk("ar_syscnt", {4'd0, syscnt}, 8'd0);
        chk("ar_wrap",   {7'd0, wrap},   8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        now = 0;
        to_edge(19);  chk("ar_pre19",    {7'd0, clk_en}, 8'd0);
        to_edge(20);  chk("ar_en20",     {7'd0, clk_en}, 8'd1);
        to_edge(21);  chk("ar_cnt21",    {4'd0, syscnt}, 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_clken_counter_gen
